// File: rtl/gpio_in_pkg.sv
// rtl/gpio_in_pkg.sv - shared constants, register map and helpers for gpio_in
//
// Purpose: bus width, load-type encoding, default base address, the register
// offsets of the 16-byte window and a small rising-edge popcount helper.
// Ports: none (package).

package gpio_in_pkg;

    localparam int WORDSIZE = 32;

    // Load-type code meaning "this cycle is not a load".
    localparam logic [2:0] NO_LOAD = 3'd0;

    // Default base address of the register window.
    localparam logic [31:0] GPIOIN_BASE = 32'h0000_0F00;

    // Register index = addr[3:2].
    typedef enum logic [1:0] {
        GPIOIN_DATA = 2'd0,
        GPIOIN_RISE = 2'd1,
        GPIOIN_FALL = 2'd2,
        GPIOIN_CNT  = 2'd3
    } gpioin_reg_e;

    function automatic logic [15:0] popcount4(input logic [3:0] v);
        popcount4 = 16'(v[0]) + 16'(v[1]) + 16'(v[2]) + 16'(v[3]);
    endfunction

endpackage

// File: rtl/gpio_in_debounce.sv
// rtl/gpio_in_debounce.sv - per-pin synchronizer and debouncer
//
// Purpose: two-flop synchronizer (s1 -> s2) followed by a debounced level.
// Configuration macro GPIO_IN_DEBOUNCE_EN:
//   defined   - deb follows s2 only after DEB_CYCLES consecutive differing cycles
//   undefined - deb follows s2 every cycle, no counter flops
// Ports:
//   CLK        in  core clock
//   reset      in  asynchronous active-low reset
//   i_pin      in  raw pin, asynchronous to CLK
//   o_deb      out registered debounced level
//   o_deb_next out value o_deb takes at the next edge (lets the parent
//                  flag edges at the same edge the level changes)

module gpio_in_debounce #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic CLK,
    input  logic reset,
    input  logic i_pin,
    output logic o_deb,
    output logic o_deb_next
);

    logic r_s1;
    logic r_s2;
    logic r_deb;
    logic w_deb_next;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_deb <= 1'b0;
        end else begin
            r_s1  <= i_pin;
            r_s2  <= r_s1;
            r_deb <= w_deb_next;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;

    // cnt counts consecutive cycles in which s2 disagrees with deb; any
    // agreement (a glitch ending) restarts it from zero.
    always_comb begin
        w_cnt_next = r_cnt;
        w_deb_next = r_deb;
        if (r_s2 == r_deb) begin
            w_cnt_next = 16'd0;
        end else if (r_cnt == DEB_CYCLES - 16'd1) begin
            w_deb_next = r_s2;
            w_cnt_next = 16'd0;
        end else begin
            w_cnt_next = r_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end
`else
    // DEB_CYCLES has no meaning without the counter.
    logic w_unused_deb_cycles;
    assign w_unused_deb_cycles = ^DEB_CYCLES;

    always_comb begin
        w_deb_next = r_s2;
    end
`endif

    assign o_deb      = r_deb;
    assign o_deb_next = w_deb_next;

endmodule

// File: rtl/gpio_in.sv
// rtl/gpio_in.sv - memory-mapped 4-bit debounced input port with edge flags
//
// Purpose: debounces four pins, keeps sticky RISE/FALL flags (W1C) and a
// 16-bit rising-edge counter, and serves single-cycle loads/stores.
// Configuration macro GPIO_IN_DEBOUNCE_EN (see gpio_in_debounce).
// Ports:
//   CLK      in  core clock
//   reset    in  asynchronous active-low reset
//   in_ja2   in  [3:0] raw pins
//   addr     in  [31:0] byte address
//   wdata    in  [31:0] store data
//   memwrite in  store strobe
//   loadops  in  [2:0] load type, NO_LOAD = no read
//   hit      out address falls in the 16-byte window
//   rdata    out [31:0] combinational read data
//   irq      out any RISE or FALL flag set

module gpio_in
    import gpio_in_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = GPIOIN_BASE,
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [3:0]          in_ja2,
    input  logic [WORDSIZE-1:0] addr,
    input  logic [WORDSIZE-1:0] wdata,
    input  logic                memwrite,
    input  logic [2:0]          loadops,
    output logic                hit,
    output logic [WORDSIZE-1:0] rdata,
    output logic                irq
);

    logic [3:0]  w_deb;
    logic [3:0]  w_deb_next;
    logic [3:0]  w_rise;
    logic [3:0]  w_fall;
    logic        w_we;
    gpioin_reg_e w_sel;
    logic [3:0]  r_rise;
    logic [3:0]  r_fall;
    logic [15:0] r_cnt;

    // Byte lanes and upper store bits are not stored anywhere.
    logic w_unused_bus;
    assign w_unused_bus = ^{addr[1:0], wdata[31:16]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pin
            gpio_in_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_debounce (
                .CLK        (CLK),
                .reset      (reset),
                .i_pin      (in_ja2[gi]),
                .o_deb      (w_deb[gi]),
                .o_deb_next (w_deb_next[gi])
            );
        end
    endgenerate

    assign hit    = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_sel  = gpioin_reg_e'(addr[3:2]);
    assign w_we   = hit && memwrite;
    assign w_rise = w_deb_next & ~w_deb;
    assign w_fall = ~w_deb_next & w_deb;

    // Clear is applied before set so a same-cycle edge keeps its flag; a CNT
    // store replaces the value outright and drops that cycle's increments.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_rise <= 4'd0;
            r_fall <= 4'd0;
            r_cnt  <= 16'd0;
        end else begin
            if (w_we && w_sel == GPIOIN_RISE) begin
                r_rise <= (r_rise & ~wdata[3:0]) | w_rise;
            end else begin
                r_rise <= r_rise | w_rise;
            end
            if (w_we && w_sel == GPIOIN_FALL) begin
                r_fall <= (r_fall & ~wdata[3:0]) | w_fall;
            end else begin
                r_fall <= r_fall | w_fall;
            end
            if (w_we && w_sel == GPIOIN_CNT) begin
                r_cnt <= wdata[15:0];
            end else begin
                r_cnt <= r_cnt + popcount4(w_rise);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (hit && loadops != NO_LOAD) begin
            case (w_sel)
                GPIOIN_DATA: rdata = {28'd0, w_deb};
                GPIOIN_RISE: rdata = {28'd0, r_rise};
                GPIOIN_FALL: rdata = {28'd0, r_fall};
                GPIOIN_CNT:  rdata = {16'd0, r_cnt};
                default:     rdata = '0;
            endcase
        end
    end

    assign irq = |{r_rise, r_fall};

endmodule
